// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer and the program counter:
// PC load-source codes, fetch state encoding and the flush opcode.
package fetch_ctrl_pkg;

    localparam logic [1:0] PC_R0   = 2'b11;
    localparam logic [1:0] PC_DM   = 2'b10;
    localparam logic [1:0] PC_OR2  = 2'b01;
    localparam logic [1:0] PC_NONE = 2'b00;

    localparam logic [7:0] NOP_OP = 8'h00;

    typedef enum logic {
        F_OP   = 1'b0,
        F_OPND = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: steps the PC one byte per cycle, assembles one- and
// two-byte instructions for decode, and handles stall and taken-branch requests.
module fetch_ctrl #(
    parameter int unsigned LONG_BIT = 7,
    parameter logic [7:0]  NOP_OP   = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_pc_in,
    input  logic [7:0] i_im_data,
    input  logic       i_stall,
    input  logic       i_br_taken,
    input  logic [1:0] i_br_src,
    output logic       o_i_pc,
    output logic       o_l_pc,
    output logic       o_s11,
    output logic       o_s10,
    output logic [7:0] o_ir_op,
    output logic [7:0] o_or2,
    output logic [7:0] o_ir_pc,
    output logic       o_if_valid
);
    import fetch_ctrl_pkg::*;

    fetch_state_e r_state;
    logic [7:0]   r_ir_op;
    logic [7:0]   r_or2;
    logic [7:0]   r_ir_pc;
    logic         r_if_valid;

    fetch_state_e w_state_d;
    logic [7:0]   w_ir_op_d;
    logic [7:0]   w_or2_d;
    logic [7:0]   w_ir_pc_d;
    logic         w_if_valid_d;
    logic         w_branch;
    logic [1:0]   w_sel;

    // A branch with the illegal source code 00 is treated as no branch at all.
    assign w_branch = i_br_taken && (i_br_src != PC_NONE);

    always_comb begin
        o_i_pc       = 1'b0;
        o_l_pc       = 1'b0;
        w_sel        = PC_NONE;
        w_state_d    = r_state;
        w_ir_op_d    = r_ir_op;
        w_or2_d      = r_or2;
        w_ir_pc_d    = r_ir_pc;
        w_if_valid_d = r_if_valid;

        if (!i_rst_n) begin
            o_i_pc = 1'b0;
        end else if (w_branch) begin
            // OR2 is kept: the PC may be loading from it on this same edge.
            o_l_pc       = 1'b1;
            w_sel        = i_br_src;
            w_state_d    = F_OP;
            w_ir_op_d    = NOP_OP;
            w_if_valid_d = 1'b0;
        end else if (!i_stall) begin
            o_i_pc = 1'b1;
            unique case (r_state)
                F_OP: begin
                    w_ir_op_d = i_im_data;
                    w_ir_pc_d = i_pc_in;
                    if (i_im_data[LONG_BIT]) begin
                        w_state_d    = F_OPND;
                        w_if_valid_d = 1'b0;
                    end else begin
                        w_state_d    = F_OP;
                        w_if_valid_d = 1'b1;
                    end
                end
                F_OPND: begin
                    w_or2_d      = i_im_data;
                    w_if_valid_d = 1'b1;
                    w_state_d    = F_OP;
                end
                default: w_state_d = F_OP;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= F_OP;
            r_ir_op    <= NOP_OP;
            r_or2      <= 8'h00;
            r_ir_pc    <= 8'h00;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ir_op    <= w_ir_op_d;
            r_or2      <= w_or2_d;
            r_ir_pc    <= w_ir_pc_d;
            r_if_valid <= w_if_valid_d;
        end
    end

    assign o_s11      = w_sel[1];
    assign o_s10      = w_sel[0];
    assign o_ir_op    = r_ir_op;
    assign o_or2      = r_or2;
    assign o_ir_pc    = r_ir_pc;
    assign o_if_valid = r_if_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random stall/branch
// traffic, compared against an instruction-level model with its own PC and memory.
module tb_fetch_ctrl;

    localparam logic [7:0] R0_VAL = 8'h3C;
    localparam logic [7:0] DM_VAL = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pc = 8'h00;
    logic [7:0] im_data;
    logic       stall = 1'b0;
    logic       br_taken = 1'b0;
    logic [1:0] br_src = 2'b00;
    logic       i_pc, l_pc, s11, s10, if_valid;
    logic [7:0] ir_op, or2, ir_pc;

    logic [7:0] mem [256];

    // Model: the instruction as decode should see it, plus "opcode waiting for operand".
    logic [7:0] m_op, m_or2, m_irpc;
    logic       m_valid, m_pend;

    int n_checks = 0;
    int n_errors = 0;

    assign im_data = mem[pc];

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pc_in    (pc),
        .i_im_data  (im_data),
        .i_stall    (stall),
        .i_br_taken (br_taken),
        .i_br_src   (br_src),
        .o_i_pc     (i_pc),
        .o_l_pc     (l_pc),
        .o_s11      (s11),
        .o_s10      (s10),
        .o_ir_op    (ir_op),
        .o_or2      (or2),
        .o_ir_pc    (ir_pc),
        .o_if_valid (if_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_op = 8'h00; m_or2 = 8'h00; m_irpc = 8'h00; m_valid = 1'b0; m_pend = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".ir_op"}, ir_op, m_op);
        check({tag, ".or2"}, or2, m_or2);
        check({tag, ".ir_pc"}, ir_pc, m_irpc);
        check({tag, ".valid"}, if_valid, m_valid);
    endtask

    // Called just after a falling edge: drive, check, cross one rising edge, update model.
    task automatic cycle(input logic st, input logic br, input logic [1:0] src);
        logic       brv;
        logic [7:0] b_v, pc_v;
        stall = st; br_taken = br; br_src = src;
        #1;
        brv = br && (src != 2'b00);
        check("i_pc", i_pc, !brv && !st);
        check("l_pc", l_pc, brv);
        check("sel", {s11, s10}, brv ? src : 2'b00);
        check_regs("cyc");
        b_v = mem[pc];
        pc_v = pc;
        @(posedge clk);
        @(negedge clk);
        if (brv) begin
            m_valid = 1'b0; m_op = 8'h00; m_pend = 1'b0;
            case (src)
                2'b11:   pc = R0_VAL;
                2'b10:   pc = DM_VAL;
                default: pc = m_or2;
            endcase
        end else if (!st) begin
            if (m_pend) begin
                m_or2 = b_v; m_valid = 1'b1; m_pend = 1'b0;
            end else begin
                m_op = b_v; m_irpc = pc_v; m_pend = b_v[7]; m_valid = !b_v[7];
            end
            pc = pc + 8'h01;
        end
        stall = 1'b0; br_taken = 1'b0; br_src = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        model_reset();

        // Reset held for two cycles with a non-NOP byte on the bus.
        mem[0] = 8'h12;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.i_pc", i_pc, 1'b0);
        check("rst.l_pc", l_pc, 1'b0);
        check("rst.ir_op", ir_op, 8'h00);
        check("rst.valid", if_valid, 1'b0);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 2'b00);
        check("first.ir_op", ir_op, 8'h12);
        check("first.ir_pc", ir_pc, 8'h00);
        check("first.valid", if_valid, 1'b1);

        // Short then long instruction.
        pc = 8'h10; mem[8'h10] = 8'h05; mem[8'h11] = 8'h83; mem[8'h12] = 8'h40;
        cycle(1'b0, 1'b0, 2'b00);
        check("short.ir_op", ir_op, 8'h05);
        check("short.ir_pc", ir_pc, 8'h10);
        check("short.valid", if_valid, 1'b1);
        cycle(1'b0, 1'b0, 2'b00);
        check("long_gap.valid", if_valid, 1'b0);
        cycle(1'b0, 1'b0, 2'b00);
        check("long.ir_op", ir_op, 8'h83);
        check("long.or2", or2, 8'h40);
        check("long.ir_pc", ir_pc, 8'h11);
        check("long.valid", if_valid, 1'b1);

        // Three-cycle stall while waiting for the operand.
        pc = 8'h20; mem[8'h20] = 8'h85; mem[8'h21] = 8'h3C;
        cycle(1'b0, 1'b0, 2'b00);
        repeat (3) cycle(1'b1, 1'b0, 2'b00);
        check("stall.ir_op", ir_op, 8'h85);
        check("stall.or2", or2, 8'h40);
        check("stall.valid", if_valid, 1'b0);
        check("stall.pc", pc, 8'h21);
        cycle(1'b0, 1'b0, 2'b00);
        check("resume.or2", or2, 8'h3C);
        check("resume.valid", if_valid, 1'b1);

        // Branch to OR2 while in operand fetch, with a simultaneous stall.
        pc = 8'h40; mem[8'h40] = 8'hA0; mem[8'h41] = 8'h11;
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 2'b01);
        check("br.valid", if_valid, 1'b0);
        check("br.ir_op", ir_op, 8'h00);
        check("br.or2_kept", or2, 8'h3C);
        pc = 8'h50; mem[8'h50] = 8'h07; mem[8'h51] = 8'h08;
        cycle(1'b0, 1'b0, 2'b00);
        check("br_fop.ir_op", ir_op, 8'h07);
        check("br_fop.valid", if_valid, 1'b1);

        // Illegal branch source: normal fetch proceeds.
        cycle(1'b0, 1'b1, 2'b00);
        check("br00.ir_op", ir_op, 8'h08);
        check("br00.ir_pc", ir_pc, 8'h51);

        // Opcode at FF, operand wrapped to 00.
        pc = 8'hFF; mem[8'hFF] = 8'h9A; mem[8'h00] = 8'h77;
        cycle(1'b0, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b00);
        check("wrap.ir_op", ir_op, 8'h9A);
        check("wrap.or2", or2, 8'h77);
        check("wrap.ir_pc", ir_pc, 8'hFF);
        check("wrap.valid", if_valid, 1'b1);

        // Asynchronous reset in the middle of operand fetch.
        pc = 8'h30; mem[8'h30] = 8'hC1;
        cycle(1'b0, 1'b0, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("arst");
        check("arst.i_pc", i_pc, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic over random memory contents.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                  2'($urandom_range(0, 3)));
        end
        #1;
        check_regs("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
